dmem_hs_ctrl: RTL
=================

# dmem_hs_ctrl

Parametrised, handshaked data memory for the RISC-V core. It replaces the fixed 16-word data memory, which uses single-cycle `mem_read`/`mem_write` strobes. Depth, data width and access latency are configurable. It adds byte-strobe writes, a valid/ready request/response handshake and a post-reset hardware clear sequence. It sits between the core's load/store unit and the backing storage array.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits; a multiple of 8, power of two.
- `ADDR_W`, 12, byte-address width.
- `DEPTH`, 256, number of words; at most 2^(ADDR_W-OFFS), where OFFS = log2(DATA_W/8).
- `LATENCY`, 2, cycles from request acceptance to `rsp_valid`; must be at least 1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data.
- `req_be` in DATA_W/8: byte strobes for stores; ignored on loads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out DATA_W: load data; 0 for stores and for errored accesses.
- `rsp_err` out 1: access error (see Configuration).
- `clr_busy` out 1: clear sequence in progress.

## Operation
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR
  - Entered on `rst`.
  - Writes zero to word index 0..DEPTH-1, one word per cycle, using a clear counter.
  - Moves to IDLE after the write to index DEPTH-1.
  - `clr_busy`=1 while in this state.
- IDLE
  - `req_ready`=1.
  - On `req_valid && req_ready`: word index = `req_addr[ADDR_W-1:OFFS]`, and the low OFFS address bits are ignored.
  - Store: bytes with `req_be[i]`=1 are written on the acceptance edge. Bytes with strobe 0 keep their value. An all-zero strobe writes nothing but still produces a response.
  - Load: the addressed word is captured into the response register on the acceptance edge.
  - Next state is WAIT if LATENCY>1, otherwise RESP. The latency counter loads LATENCY-1.
- WAIT
  - Counter decrements each cycle.
  - Moves to RESP on the edge where the counter reaches 1.
- RESP
  - `rsp_valid`=1 and the response fields are held stable.
  - On `rsp_ready`, moves to IDLE.
  - Responses are never dropped.
- Only one transaction is outstanding at a time. `req_ready`=0 in every state other than IDLE.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `clr_busy`=1.
  - State = CLEAR, clear counter = 0.
- First `req_ready`=1 occurs DEPTH cycles after the reset edge.
- A request accepted at edge N gives `rsp_valid`=1 in the cycle after edge N+LATENCY-1.
- With `rsp_ready` held at 1, the next acceptance can happen at edge N+LATENCY+1.
- Boundary conditions:
  - Reset asserted mid-transaction aborts it. `rsp_valid` drops on that edge and the clear sequence restarts from index 0.
  - A store that was already accepted is not undone; the clear overwrites it anyway.
  - A load that hits a word stored in the previous transaction returns the new data (store-then-load ordering).
  - `rsp_ready` held low keeps the block in RESP indefinitely.
  - `req_valid` outside IDLE is ignored and the request is not latched.

## Configuration
- Macro: `DMEM_RANGE_CHECK_EN`.
- Defined: an access is flagged when the word index ≥ DEPTH, or when the low OFFS address bits are non-zero.
  - Flagged stores do not modify memory.
  - Flagged loads return 0.
  - `rsp_err`=1 in the response.
- Undefined: `rsp_err` is tied to 0 and the word index wraps modulo DEPTH. Misaligned addresses are silently aligned down.

## Structure
- Package `dmem_pkg` holds:
  - the FSM state enum;
  - the function computing OFFS;
  - the clog2 helper for the counter widths.
- One sub-module, `dmem_array`:
  - DEPTH × DATA_W storage with a single port;
  - per-byte write enable and a registered read.
- The FSM, the latency counter, the clear counter and the response register live in the top level.

## Test plan
- Reset, then poll: `clr_busy` is 1 for exactly DEPTH cycles. A load from address 0x3FC then returns 0x00000000.
- Store 0xDEADBEEF to 0x010 with `req_be`=4'hF, then a load from 0x010 with LATENCY=2: `rsp_rdata`=0xDEADBEEF, with `rsp_valid` two cycles after acceptance.
- Store 0x11223344 to 0x020 with `req_be`=4'b0101 over prior contents 0xAABBCCDD: a load returns 0xAA22CC44.
- Hold `rsp_ready`=0 for 5 cycles after a load: `rsp_valid` and `rsp_rdata` stay stable, and `req_ready` stays 0 throughout.
- Assert `rst` during WAIT: `rsp_valid` is never asserted, the clear restarts, and a later load of that address returns 0.
- With `DMEM_RANGE_CHECK_EN`, DEPTH=256: a store to 0x400 gives `rsp_err`=1 and leaves memory unchanged, and a load from 0x002 gives `rsp_err`=1 with `rsp_rdata`=0. Without the macro, the load from 0x400 returns word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constant helpers for the handshaked data memory.
package dmem_pkg;

    // Controller states: post-reset clear, ready, latency wait, response hold.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Ceiling log2, used for elaboration-time counter and index widths.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Number of byte-offset bits inside one data word.
    function automatic int offs(input int data_w);
        return clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// The read register only updates on an enabled read, so it holds load data
// stable for as long as the controller needs it.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write, or capture of the addressed word on a read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_hs_ctrl.sv
// Handshaked data memory controller: clears the array after reset, then
// serves one load/store at a time with a fixed response latency.
// Optional macro DMEM_RANGE_CHECK_EN flags out-of-range or misaligned
// accesses (no write, zero load data, rsp_err set); without it the word
// index wraps modulo DEPTH and misaligned addresses are aligned down.
module dmem_hs_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  clr_busy
);

    localparam int OFFS  = offs(DATA_W);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = ADDR_W - OFFS;
    localparam int AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int LW    = clog2(LATENCY + 1);

    // One extra bit so DEPTH == 2^IDX_W stays representable.
    localparam logic [IDX_W:0]    DEPTH_X  = (IDX_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << OFFS) - 1);
    localparam logic [AW-1:0]     CLR_LAST = AW'(DEPTH - 1);
    localparam logic [LW-1:0]     LAT_INIT = LW'(LATENCY - 1);
    localparam logic [LW-1:0]     LAT_ONE  = LW'(1);

    state_t            state, state_nx;
    logic [AW-1:0]     clr_cnt;
    logic [LW-1:0]     lat_cnt;
    logic              ld_ok_q;
    logic              err_q;
    logic              accept;
    logic              acc_err;
    logic [IDX_W-1:0]  widx;
    logic [IDX_W:0]    widx_mod;

    logic              arr_en, arr_we;
    logic [AW-1:0]     arr_addr;
    logic [BE_W-1:0]   arr_be;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;
    logic              unused_bits;

    assign widx     = req_addr[ADDR_W-1:OFFS];
    assign widx_mod = {1'b0, widx} % DEPTH_X;

`ifdef DMEM_RANGE_CHECK_EN
    assign acc_err = ({1'b0, widx} >= DEPTH_X) || ((req_addr & LOW_MASK) != '0);
    assign rsp_err = err_q;
`else
    assign acc_err = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Offset bits and the upper wrap bits are intentionally dropped.
    assign unused_bits = ^{req_addr, widx_mod, err_q};

    // Load data is only exposed for an accepted, non-errored load.
    assign rsp_rdata = ld_ok_q ? arr_rdata : '0;

    // State, clear counter, latency counter and response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            lat_cnt <= '0;
            ld_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (accept) begin
                lat_cnt <= LAT_INIT;
                ld_ok_q <= !req_write && !acc_err;
                err_q   <= acc_err;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // Next state, handshake outputs and array port steering.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        clr_busy  = 1'b0;
        accept    = 1'b0;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = widx_mod[AW-1:0];
        arr_be    = req_be;
        arr_wdata = req_wdata;
        case (state)
            CLEAR: begin
                clr_busy  = 1'b1;
                arr_en    = !rst;
                arr_we    = 1'b1;
                arr_addr  = clr_cnt;
                arr_be    = '1;
                arr_wdata = '0;
                if (clr_cnt == CLR_LAST) state_nx = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    arr_en   = !rst && !acc_err;
                    arr_we   = req_write;
                    state_nx = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_ONE) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = CLEAR;
        endcase
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk    (clk),
        .en     (arr_en),
        .we     (arr_we),
        .addr   (arr_addr),
        .be     (arr_be),
        .wdata  (arr_wdata),
        .rdata  (arr_rdata)
    );

endmodule
